// File: rtl/tt_mult_byteio_if.sv
// TinyTapeout user-project pin bundle for tt_mult_byteio, plus a debug view of the FSM state.
// slave = the multiplier core, master = whatever drives the pins (board or bench).
interface tt_mult_byteio_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [1:0] fsm_state;

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe,
    output fsm_state
  );

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe,
    input  fsm_state
  );
endinterface

// File: rtl/tt_mult_byteio.sv
// Byte-serial WIDTH x WIDTH shift-add multiplier on the TinyTapeout pin set.
// Optional macro TT_MULT_SIGNED_EN selects two's-complement operands.
//
// Handshake: a byte moves on a rising clk edge with ena=1 when both sides agree --
// in_valid (uio_in[0]) with in_ready (uio_out[2]) for operand bytes, and
// out_valid (uio_out[3]) with out_ready (uio_in[1]) for product bytes.
// in_ready/out_valid never depend on in_valid/out_ready in the same cycle.
module tt_mult_byteio #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  tt_mult_byteio_if.slave io
);
  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_IN_LAST  = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_MUL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_OUT_LAST = CW'(2 * NB - 1);

  if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("tt_mult_byteio: WIDTH must be a multiple of 8 in 8..32");
  end

  typedef enum logic [1:0] {LOAD_A, LOAD_B, MUL, OUT} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] mcand, prod;
  logic               in_ready, out_valid, busy;
  logic [7:0]         out_byte;

  logic               in_valid, out_ready;
  logic [WIDTH-1:0]   b_full, a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_sum, prod_fin;
  logic               unused_uio;

  assign in_valid   = io.uio_in[0];
  assign out_ready  = io.uio_in[1];
  assign unused_uio = ^io.uio_in[7:2];

  // b_full is operand B as it will be once the byte on ui_in is captured.
  always_comb begin
    b_full = b;
    b_full[{cnt, 3'b000} +: 8] = io.ui_in;
    prod_sum = prod + (b[0] ? mcand : '0);
  end

`ifdef TT_MULT_SIGNED_EN
  logic sign;
  assign a_abs    = a[WIDTH-1] ? -a : a;
  assign b_abs    = b_full[WIDTH-1] ? -b_full : b_full;
  assign prod_fin = sign ? -prod_sum : prod_sum;
`else
  assign a_abs    = a;
  assign b_abs    = b_full;
  assign prod_fin = prod_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      mcand     <= '0;
      prod      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_byte  <= 8'h00;
`ifdef TT_MULT_SIGNED_EN
      sign      <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            a[{cnt, 3'b000} +: 8] <= io.ui_in;
            if (cnt == CNT_IN_LAST) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            if (cnt == CNT_IN_LAST) begin
              // Multiplier goes into b (shifted right), magnitude of A into mcand (shifted left).
              b        <= b_abs;
              mcand    <= {{WIDTH{1'b0}}, a_abs};
              prod     <= '0;
              cnt      <= '0;
              state    <= MUL;
              in_ready <= 1'b0;
              busy     <= 1'b1;
`ifdef TT_MULT_SIGNED_EN
              sign     <= a[WIDTH-1] ^ b_full[WIDTH-1];
`endif
            end else begin
              b[{cnt, 3'b000} +: 8] <= io.ui_in;
              cnt <= cnt + 1'b1;
            end
          end
        end
        MUL: begin
          mcand <= mcand << 1;
          b     <= b >> 1;
          if (cnt == CNT_MUL_LAST) begin
            prod      <= prod_fin;
            out_byte  <= prod_fin[7:0];
            cnt       <= '0;
            state     <= OUT;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            prod <= prod_sum;
            cnt  <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (cnt == CNT_OUT_LAST) begin
              prod      <= '0;
              out_byte  <= 8'h00;
              cnt       <= '0;
              state     <= LOAD_A;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              // The product drains through its low byte.
              prod     <= prod >> 8;
              out_byte <= prod[15:8];
              cnt      <= cnt + 1'b1;
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign io.uo_out    = out_byte;
  assign io.uio_out   = {3'b000, busy, out_valid, in_ready, 2'b00};
  assign io.uio_oe    = 8'b0001_1100;
  assign io.fsm_state = state;
endmodule
